mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single 16-bit synchronous memory port between instruction fetch and data load/store.
- Grants at most one requester per cycle. Data access has priority, with a starvation guard for fetch.
- Records the owner of each read in a register, so the read return is steered one cycle later (registered select on the return path).
- Sits between the fetch unit, the load/store unit and the memory block.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory port.
- DATA_W, 16, data width.
- MAX_WAIT, 4, consecutive denied fetch cycles after which fetch wins a conflict; range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- ifetch_req  in  1  fetch requests a read this cycle.
- ifetch_addr  in  ADDR_W  fetch address.
- ifetch_gnt  out  1  fetch request accepted this cycle.
- ifetch_rvalid  out  1  fetch read data valid on rdata.
- data_req  in  1  load/store request.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_gnt  out  1  load/store accepted; for stores, this is completion.
- data_rvalid  out  1  load data valid on rdata.
- rdata  out  DATA_W  mem_rdata passed through, unregistered.
- mem_ready  in  1  memory can accept an access this cycle.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_en.
- stall_cnt  out  16  saturating count of denied fetch cycles (debug).

Behaviour:
- Reset (RST_N low, asynchronous):
  - wait_cnt = 0, r_valid_q = 0, r_owner_q = 0, stall_cnt = 0.
  - ifetch_gnt, data_gnt, mem_en, mem_we, ifetch_rvalid and data_rvalid are forced to 0 while RST_N is low.
- Grant decision (combinational, same cycle as the request):
  - If mem_ready = 0: no grant.
  - Else if data_req and not (ifetch_req and wait_cnt == MAX_WAIT): data_gnt = 1.
  - Else if ifetch_req: ifetch_gnt = 1.
  - The two grants are never high together.
- Port drive:
  - mem_en = ifetch_gnt | data_gnt.
  - mem_we = data_gnt & data_we.
  - mem_addr = data_addr when data_gnt, else ifetch_addr.
  - mem_wdata = data_wdata always.
- wait_cnt (registered):
  - Cleared when ifetch_gnt or when not ifetch_req.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Counts regardless of mem_ready.
- Return path:
  - At each posedge: r_valid_q <= mem_en & ~mem_we; r_owner_q <= data_gnt.
  - In the following cycle: ifetch_rvalid = r_valid_q & ~r_owner_q; data_rvalid = r_valid_q & r_owner_q.
  - Read latency is exactly 1 cycle after the grant.
  - Back-to-back reads from alternating owners each return in order, one per cycle.
  - Stores never produce an rvalid.
- stall_cnt: increments when ifetch_req & ~ifetch_gnt; saturates at 16'hFFFF.
- When mem_ready falls, the pending return from the previous cycle still completes. Requesters must hold req/addr until granted.
- Reset mid-read: the return is dropped and no rvalid is produced after reset is released.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W defaults.
  - Owner encoding constants OWNER_IFETCH = 0, OWNER_DATA = 1.
- One natural sub-module: arb_return_steer. It holds r_valid_q/r_owner_q and drives both rvalid outputs.
- The grant logic and counters stay in the top module.

Test Plan:
- Single fetch: ifetch_req = 1, addr 16'h0010, mem_rdata = 16'hBEEF next cycle -> ifetch_gnt = 1 in cycle 0; ifetch_rvalid = 1 with rdata = 16'hBEEF in cycle 1; data_rvalid = 0.
- Conflict: both requesting, data load at 16'h0200 -> data_gnt = 1, mem_addr = 16'h0200, ifetch_gnt = 0; data_rvalid = 1 next cycle; stall_cnt = 1.
- Starvation: both held high for 6 cycles, MAX_WAIT = 4 -> data granted in cycles 0-3, fetch granted in cycle 4, data in cycle 5; wait_cnt is 0 after cycle 4.
- Store: data_req = 1, data_we = 1, addr 16'h0300, wdata 16'h1234 -> mem_en = mem_we = 1 with that address/data; no rvalid in the next cycle.
- mem_ready = 0 for 3 cycles with fetch pending -> no grants, mem_en = 0, stall_cnt += 3. Fetch is granted on the first cycle mem_ready = 1.
- RST_N pulsed low in the cycle after a fetch grant -> ifetch_rvalid = 0, all outputs 0 during reset, stall_cnt = 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults and owner encoding for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_WAIT_DEF = 4;

    // Owner tag recorded with each read so the return can be steered a cycle later.
    localparam logic OWNER_IFETCH = 1'b0;
    localparam logic OWNER_DATA   = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_return_steer.sv
// Remembers which requester owns the read in flight and raises that requester's rvalid
// in the cycle the memory returns data.
module arb_return_steer
    import mem_port_arbiter_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    input  logic mem_en,
    input  logic mem_we,
    input  logic data_gnt,
    output logic ifetch_rvalid,
    output logic data_rvalid
);

    logic r_valid_q;
    logic r_owner_q;

    // Stage boundary: grant cycle -> memory return cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid_q <= 1'b0;
            r_owner_q <= OWNER_IFETCH;
        end else begin
            r_valid_q <= mem_en & ~mem_we;
            r_owner_q <= data_gnt ? OWNER_DATA : OWNER_IFETCH;
        end
    end

    always_comb begin
        ifetch_rvalid = RST_N & r_valid_q & (r_owner_q == OWNER_IFETCH);
        data_rvalid   = RST_N & r_valid_q & (r_owner_q == OWNER_DATA);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: load/store has priority, fetch wins a conflict after
// MAX_WAIT consecutive denied cycles. Read returns are steered one cycle after the grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ifetch_req,
    input  logic [ADDR_W-1:0] ifetch_addr,
    output logic              ifetch_gnt,
    output logic              ifetch_rvalid,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              mem_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt
);

    localparam int WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic              fetch_turn;

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v == WAIT_LIMIT) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Fetch has been starved long enough to take a conflict from load/store.
    assign fetch_turn = ifetch_req && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        ifetch_gnt = 1'b0;
        data_gnt   = 1'b0;
        if (RST_N && mem_ready) begin
            if (data_req && !fetch_turn) begin
                data_gnt = 1'b1;
            end else if (ifetch_req) begin
                ifetch_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = ifetch_gnt | data_gnt;
        mem_we    = data_gnt & data_we;
        mem_addr  = data_gnt ? data_addr : ifetch_addr;
        mem_wdata = data_wdata;
        rdata     = mem_rdata;
    end

    // Stage boundary: request cycle -> starvation/debug counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (ifetch_gnt || !ifetch_req) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= sat_inc_wait(wait_cnt);
            end
            if (ifetch_req && !ifetch_gnt) begin
                stall_cnt <= sat_inc16(stall_cnt);
            end
        end
    end

    arb_return_steer u_return_steer (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .data_gnt      (data_gnt),
        .ifetch_rvalid (ifetch_rvalid),
        .data_rvalid   (data_rvalid)
    );

endmodule
